// File: rtl/flash_seq_pkg.sv
// flash_seq_pkg: shared types and constants for the PRG flash command sequencer.
//   fop_t        - request opcode (req_op encoding)
//   fsm_state_t  - bus-cycle phase encoding
//   seq_state_t  - sequencer control state
//   cmd_t        - one entry of the JEDEC command list
//   cmd_rom()    - command list indexed by op and step
package flash_seq_pkg;

   typedef enum logic [1:0] {
      FOP_PROGRAM      = 2'd0,
      FOP_SECTOR_ERASE = 2'd1,
      FOP_CHIP_ERASE   = 2'd2,
      FOP_RESET        = 2'd3
   } fop_t;

   typedef enum logic [2:0] {
      IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_SAMPLE, ABORT, DONE
   } fsm_state_t;

   typedef enum logic [2:0] {
      SEQ_IDLE, SEQ_CMD, SEQ_POLL, SEQ_ABORT, SEQ_DONE
   } seq_state_t;

   localparam logic [7:0] CMD_AA = 8'hAA;
   localparam logic [7:0] CMD_55 = 8'h55;
   localparam logic [7:0] CMD_A0 = 8'hA0;
   localparam logic [7:0] CMD_80 = 8'h80;
   localparam logic [7:0] CMD_30 = 8'h30;
   localparam logic [7:0] CMD_10 = 8'h10;
   localparam logic [7:0] CMD_F0 = 8'hF0;

   localparam logic [11:0] UNLOCK_A = 12'hAAA;
   localparam logic [11:0] UNLOCK_B = 12'h555;

   // use_addr/use_data select the latched request address/data instead of
   // the constant fields; last marks the final write of the list.
   typedef struct packed {
      logic        use_addr;
      logic        use_data;
      logic        last;
      logic [11:0] addr;
      logic [7:0]  data;
   } cmd_t;

   function automatic cmd_t cmd_rom(fop_t op, logic [2:0] step);
      cmd_t e;
      e = '0;
      case (op)
         FOP_PROGRAM: begin
            case (step)
               3'd0: begin e.addr = UNLOCK_A; e.data = CMD_AA; end
               3'd1: begin e.addr = UNLOCK_B; e.data = CMD_55; end
               3'd2: begin e.addr = UNLOCK_A; e.data = CMD_A0; end
               default: begin e.use_addr = 1'b1; e.use_data = 1'b1; e.last = 1'b1; end
            endcase
         end
         FOP_SECTOR_ERASE, FOP_CHIP_ERASE: begin
            case (step)
               3'd0: begin e.addr = UNLOCK_A; e.data = CMD_AA; end
               3'd1: begin e.addr = UNLOCK_B; e.data = CMD_55; end
               3'd2: begin e.addr = UNLOCK_A; e.data = CMD_80; end
               3'd3: begin e.addr = UNLOCK_A; e.data = CMD_AA; end
               3'd4: begin e.addr = UNLOCK_B; e.data = CMD_55; end
               default: begin
                  e.last = 1'b1;
                  if (op == FOP_SECTOR_ERASE) begin
                     e.use_addr = 1'b1;
                     e.data     = CMD_30;
                  end else begin
                     e.addr = UNLOCK_A;
                     e.data = CMD_10;
                  end
               end
            endcase
         end
         default: begin
            e.data = CMD_F0;
            e.last = 1'b1;
         end
      endcase
      return e;
   endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// flash_bus_cycle: strobe timing for one flash write or read cycle.
//   m2, rst   - clock, synchronous active-high reset
//   start, rd - begin a cycle (rd=1 read, rd=0 write); may be raised in the
//               last cycle of the current one for back-to-back cycles
//   cyc_last  - current cycle is in its final phase (W_HOLD or R_SAMPLE)
//   ce_n, oe_n, we_n, dq_oe - registered flash strobes
// Write: W_SETUP (1) -> W_PULSE (WE_PULSE) -> W_HOLD (1).
// Read:  R_SETUP (1) -> R_SAMPLE (1).
module flash_bus_cycle
   import flash_seq_pkg::*;
#(
   parameter int unsigned WE_PULSE = 2
) (
   input  logic m2,
   input  logic rst,
   input  logic start,
   input  logic rd,
   output logic cyc_last,
   output logic ce_n,
   output logic oe_n,
   output logic we_n,
   output logic dq_oe
);

   fsm_state_t state, nxt;
   logic [3:0] pulse_cnt;

   assign cyc_last = (state == W_HOLD) || (state == R_SAMPLE);

   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE, W_HOLD, R_SAMPLE:
            if (start) nxt = rd ? R_SETUP : W_SETUP;
         W_SETUP:  nxt = W_PULSE;
         W_PULSE:  nxt = (pulse_cnt == 4'(WE_PULSE - 1)) ? W_HOLD : W_PULSE;
         R_SETUP:  nxt = R_SAMPLE;
         default:  nxt = IDLE;
      endcase
   end

   // Strobes are decoded from the next state so they change on the same edge
   // as the phase and come straight out of flops.
   always_ff @(posedge m2) begin
      if (rst) begin
         state     <= IDLE;
         pulse_cnt <= '0;
         ce_n      <= 1'b1;
         oe_n      <= 1'b1;
         we_n      <= 1'b1;
         dq_oe     <= 1'b0;
      end else begin
         state     <= nxt;
         pulse_cnt <= (state == W_PULSE) ? pulse_cnt + 4'd1 : '0;
         ce_n      <= (nxt == IDLE);
         oe_n      <= !((nxt == R_SETUP) || (nxt == R_SAMPLE));
         we_n      <= (nxt != W_PULSE);
         dq_oe     <= (nxt == W_SETUP) || (nxt == W_PULSE) || (nxt == W_HOLD);
      end
   end

endmodule

// File: rtl/flash_cmd_sequencer.sv
// flash_cmd_sequencer: issues JEDEC program / sector erase / chip erase /
// reset command lists to the PRG flash and runs Data# polling.
//   m2, rst                  - clock, synchronous active-high reset
//   req_valid/req_ready      - request handshake (ready only in idle)
//   req_op/req_addr/req_data - opcode, target address, program byte
//   busy, done, error        - status (done one-cycle pulse, error sticky)
//   cpu_hold                 - equals busy; top muxes flash pins here
//   flash_*                  - flash address, data and active-low strobes
// Optional macro FLASH_SEQ_TIMEOUT_EN: abort polling after POLL_TIMEOUT reads.
module flash_cmd_sequencer
   import flash_seq_pkg::*;
#(
   parameter int unsigned ADDR_W       = 27,
   parameter int unsigned WE_PULSE     = 2,
   parameter logic [19:0] POLL_TIMEOUT = 20'hFFFFF
) (
   input  logic              m2,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [7:0]        req_data,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              cpu_hold,
   output logic [ADDR_W-1:0] flash_addr,
   output logic [7:0]        flash_dq_out,
   output logic              flash_dq_oe,
   input  logic [7:0]        flash_dq_in,
   output logic              flash_ce_n,
   output logic              flash_oe_n,
   output logic              flash_we_n
);

   seq_state_t        ctl;
   fop_t              op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        data_q;
   logic [2:0]        step;
   logic              dq5_seen;
   cmd_t              cur_e, nxt_e, first_e;
   logic              cyc_last, bus_start, bus_rd;
   logic              poll_match, poll_abort, timeout_hit;
   logic              unused_dq;

   assign cur_e      = cmd_rom(op_q, step);
   assign nxt_e      = cmd_rom(op_q, step + 3'd1);
   assign first_e    = cmd_rom(fop_t'(req_op), 3'd0);
   assign poll_match = flash_dq_in[7] == ((op_q == FOP_PROGRAM) ? data_q[7] : 1'b1);
   assign poll_abort = dq5_seen || timeout_hit;
   assign cpu_hold   = busy;
   assign unused_dq  = ^{flash_dq_in[6], flash_dq_in[4:0]};

`ifdef FLASH_SEQ_TIMEOUT_EN
   logic [19:0] poll_cnt;

   // Counts completed poll reads; held at zero outside polling.
   always_ff @(posedge m2) begin
      if (rst || ctl != SEQ_POLL) poll_cnt <= '0;
      else if (cyc_last)          poll_cnt <= poll_cnt + 20'd1;
   end

   assign timeout_hit = ({1'b0, poll_cnt} + 21'd1) >= {1'b0, POLL_TIMEOUT};
`else
   logic [19:0] unused_poll_timeout;

   // Timeout limit has no effect in this build.
   assign unused_poll_timeout = POLL_TIMEOUT;
   assign timeout_hit         = 1'b0;
`endif

   // Start the next bus cycle in the final phase of the current one so
   // list entries and poll reads run back to back with no idle gap.
   always_comb begin
      bus_start = 1'b0;
      bus_rd    = 1'b0;
      case (ctl)
         SEQ_IDLE: bus_start = req_valid;
         SEQ_CMD:
            if (cyc_last) begin
               if (!cur_e.last) begin
                  bus_start = 1'b1;
               end else if (op_q != FOP_RESET) begin
                  bus_start = 1'b1;
                  bus_rd    = 1'b1;
               end
            end
         SEQ_POLL:
            if (cyc_last && !poll_match) begin
               bus_start = 1'b1;
               bus_rd    = !poll_abort;
            end
         default: ;
      endcase
   end

   always_ff @(posedge m2) begin
      if (rst) begin
         ctl          <= SEQ_IDLE;
         op_q         <= FOP_PROGRAM;
         addr_q       <= '0;
         data_q       <= '0;
         step         <= '0;
         dq5_seen     <= 1'b0;
         req_ready    <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         flash_addr   <= '0;
         flash_dq_out <= '0;
      end else begin
         case (ctl)
            SEQ_IDLE:
               if (req_valid) begin
                  ctl          <= SEQ_CMD;
                  op_q         <= fop_t'(req_op);
                  addr_q       <= req_addr;
                  data_q       <= req_data;
                  step         <= '0;
                  req_ready    <= 1'b0;
                  busy         <= 1'b1;
                  error        <= 1'b0;
                  flash_addr   <= ADDR_W'(first_e.addr);
                  flash_dq_out <= first_e.data;
               end
            SEQ_CMD:
               if (cyc_last) begin
                  if (!cur_e.last) begin
                     step         <= step + 3'd1;
                     flash_addr   <= nxt_e.use_addr ? addr_q : ADDR_W'(nxt_e.addr);
                     flash_dq_out <= nxt_e.use_data ? data_q : nxt_e.data;
                  end else if (op_q == FOP_RESET) begin
                     ctl  <= SEQ_DONE;
                     done <= 1'b1;
                  end else begin
                     ctl      <= SEQ_POLL;
                     dq5_seen <= 1'b0;
                  end
               end
            SEQ_POLL:
               if (cyc_last) begin
                  if (poll_match) begin
                     ctl  <= SEQ_DONE;
                     done <= 1'b1;
                  end else if (poll_abort) begin
                     ctl          <= SEQ_ABORT;
                     error        <= 1'b1;
                     flash_addr   <= '0;
                     flash_dq_out <= CMD_F0;
                  end else if (flash_dq_in[5]) begin
                     dq5_seen <= 1'b1;
                  end
               end
            SEQ_ABORT:
               if (cyc_last) begin
                  ctl  <= SEQ_DONE;
                  done <= 1'b1;
               end
            SEQ_DONE: begin
               ctl       <= SEQ_IDLE;
               done      <= 1'b0;
               busy      <= 1'b0;
               req_ready <= 1'b1;
            end
            default: ctl <= SEQ_IDLE;
         endcase
      end
   end

   flash_bus_cycle #(.WE_PULSE(WE_PULSE)) u_bus (
      .m2       (m2),
      .rst      (rst),
      .start    (bus_start),
      .rd       (bus_rd),
      .cyc_last (cyc_last),
      .ce_n     (flash_ce_n),
      .oe_n     (flash_oe_n),
      .we_n     (flash_we_n),
      .dq_oe    (flash_dq_oe)
   );

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// tb_flash_cmd_sequencer: scoreboard bench for flash_cmd_sequencer.
// Stimulus pushes expected flash writes, poll reads and done events into a
// queue; a monitor that also plays the flash data bus pops and compares.
module tb_flash_cmd_sequencer;

   localparam int unsigned AW = 27;
   localparam int unsigned WP = 2;
   localparam int K_W = 0;
   localparam int K_R = 1;
   localparam int K_D = 2;
`ifdef FLASH_SEQ_TIMEOUT_EN
   localparam int NBUSY = 6;
`else
   localparam int NBUSY = 10;
`endif

   logic          m2 = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    req_op = 2'd0;
   logic [AW-1:0] req_addr = '0;
   logic [7:0]    req_data = '0;
   logic          busy, done, error, cpu_hold;
   logic [AW-1:0] flash_addr;
   logic [7:0]    flash_dq_out;
   logic          flash_dq_oe;
   logic [7:0]    flash_dq_in;
   logic          flash_ce_n, flash_oe_n, flash_we_n;

   always #5 m2 = ~m2;

   flash_cmd_sequencer #(
      .ADDR_W       (AW),
      .WE_PULSE     (WP),
      .POLL_TIMEOUT (20'd8)
   ) dut (
      .m2           (m2),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .cpu_hold     (cpu_hold),
      .flash_addr   (flash_addr),
      .flash_dq_out (flash_dq_out),
      .flash_dq_oe  (flash_dq_oe),
      .flash_dq_in  (flash_dq_in),
      .flash_ce_n   (flash_ce_n),
      .flash_oe_n   (flash_oe_n),
      .flash_we_n   (flash_we_n)
   );

   typedef struct {
      int            kind;
      logic [AW-1:0] addr;
      logic [7:0]    data;
      logic          err;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] resp_q[$];
   logic [7:0] resp_default = 8'h00;
   int         checks = 0;
   int         errors = 0;
   int         viol = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic push_ev(input int kind, input logic [AW-1:0] a, input logic [7:0] d, input logic err);
      ev_t e;
      e.kind = kind; e.addr = a; e.data = d; e.err = err;
      exp_q.push_back(e);
   endtask

   task automatic push_reads(input int n);
      for (int i = 0; i < n; i++) push_ev(K_R, '0, '0, 1'b0);
   endtask

   task automatic observe(input int kind, input logic [AW-1:0] a, input logic [7:0] d, input logic err);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event kind=%0d addr=%0h data=%0h required no event t=%0t",
                  kind, a, d, $time);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", 32'(kind), 32'(e.kind));
         if (kind == e.kind && kind == K_W) begin
            check("write_addr", 32'(a), 32'(e.addr));
            check("write_data", 32'(d), 32'(e.data));
         end else if (kind == e.kind && kind == K_D) begin
            check("done_error", 32'(err), 32'(e.err));
         end
      end
   endtask

   // Monitor and flash read model.
   initial begin : monitor
      logic prev_we;
      bit   rd_phase;
      prev_we     = 1'b1;
      rd_phase    = 1'b0;
      flash_dq_in = '0;
      forever begin
         @(negedge m2);
         if ((!flash_oe_n && !flash_we_n) || (flash_dq_oe && (!flash_oe_n || flash_ce_n)))
            viol++;
         if (!flash_oe_n) begin
            if (!rd_phase) begin
               if (resp_q.size() > 0) flash_dq_in = resp_q.pop_front();
               else                   flash_dq_in = resp_default;
               rd_phase = 1'b1;
            end else begin
               rd_phase = 1'b0;
               observe(K_R, flash_addr, flash_dq_in, 1'b0);
            end
         end else begin
            rd_phase = 1'b0;
         end
         if (!flash_we_n && prev_we) observe(K_W, flash_addr, flash_dq_out, 1'b0);
         prev_we = flash_we_n;
         if (done) observe(K_D, '0, '0, error);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish t=%0t", $time);
      $fatal(1);
   end

   task automatic check_reset_vals();
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
      check("rst_ce_n", 32'(flash_ce_n), 32'd1);
      check("rst_oe_n", 32'(flash_oe_n), 32'd1);
      check("rst_we_n", 32'(flash_we_n), 32'd1);
      check("rst_dq_oe", 32'(flash_dq_oe), 32'd0);
      check("rst_addr", 32'(flash_addr), 32'd0);
      check("rst_dq_out", 32'(flash_dq_out), 32'd0);
   endtask

   task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [7:0] d);
      int unsigned n;
      n = 0;
      while (!req_ready && n < 200) begin @(negedge m2); n++; end
      check("ready_before_issue", 32'(req_ready), 32'd1);
      req_op = op; req_addr = a; req_data = d; req_valid = 1'b1;
      @(negedge m2);
      req_valid = 1'b0;
      check("busy_after_accept", 32'(busy), 32'd1);
      check("cpu_hold_after_accept", 32'(cpu_hold), 32'd1);
      check("error_clear_on_accept", 32'(error), 32'd0);
   endtask

   task automatic drain(input string name);
      int unsigned n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin @(negedge m2); n++; end
      check(name, 32'(exp_q.size()), 32'd0);
      repeat (4) @(negedge m2);
   endtask

   task automatic push_prog(input logic [AW-1:0] a, input logic [7:0] d);
      push_ev(K_W, 27'hAAA, 8'hAA, 1'b0);
      push_ev(K_W, 27'h555, 8'h55, 1'b0);
      push_ev(K_W, 27'hAAA, 8'hA0, 1'b0);
      push_ev(K_W, a, d, 1'b0);
   endtask

   initial begin : stimulus
      int unsigned lat;
      int unsigned n;
      repeat (3) @(negedge m2);
      check_reset_vals();
      rst = 1'b0;
      @(negedge m2);

      // PROGRAM: two mismatching polls then a match.
      push_prog(27'h012345, 8'h5A);
      push_reads(3);
      push_ev(K_D, '0, '0, 1'b0);
      resp_q.push_back(8'h80); resp_q.push_back(8'h80); resp_q.push_back(8'h5A);
      issue(2'd0, 27'h012345, 8'h5A);
      // Requests while busy must be dropped, not queued.
      req_op = 2'd3; req_valid = 1'b1;
      repeat (3) @(negedge m2);
      check("ready_low_while_busy", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      drain("drain_program");

      // SECTOR_ERASE: erase polls expect DQ7=1.
      push_ev(K_W, 27'hAAA, 8'hAA, 1'b0);
      push_ev(K_W, 27'h555, 8'h55, 1'b0);
      push_ev(K_W, 27'hAAA, 8'h80, 1'b0);
      push_ev(K_W, 27'hAAA, 8'hAA, 1'b0);
      push_ev(K_W, 27'h555, 8'h55, 1'b0);
      push_ev(K_W, 27'h040000, 8'h30, 1'b0);
      push_reads(NBUSY + 1);
      push_ev(K_D, '0, '0, 1'b0);
      for (int i = 0; i < NBUSY; i++) resp_q.push_back(8'h00);
      resp_q.push_back(8'h80);
      issue(2'd1, 27'h040000, 8'h00);
      drain("drain_sector_erase");

      // PROGRAM with DQ5 set and DQ7 never matching: abort path.
      resp_default = 8'h20;
      push_prog(27'h000123, 8'h80);
      push_reads(2);
      push_ev(K_W, 27'h0, 8'hF0, 1'b0);
      push_ev(K_D, '0, '0, 1'b1);
      issue(2'd0, 27'h000123, 8'h80);
      drain("drain_dq5_abort");
      check("error_sticky", 32'(error), 32'd1);
      resp_default = 8'h00;

`ifdef FLASH_SEQ_TIMEOUT_EN
      // Poll timeout after 8 reads.
      push_prog(27'h000200, 8'h80);
      push_reads(8);
      push_ev(K_W, 27'h0, 8'hF0, 1'b0);
      push_ev(K_D, '0, '0, 1'b1);
      issue(2'd0, 27'h000200, 8'h80);
      drain("drain_timeout");
`endif

      // RESET op latency, then a request held through the done cycle.
      push_ev(K_W, 27'h0, 8'hF0, 1'b0);
      push_ev(K_D, '0, '0, 1'b0);
      push_ev(K_W, 27'h0, 8'hF0, 1'b0);
      push_ev(K_D, '0, '0, 1'b0);
      issue(2'd3, 27'h001234, 8'h00);
      lat = 1;
      while (!done && lat < 50) begin @(negedge m2); lat++; end
      check("reset_op_done_latency", lat, WP + 3);
      req_op = 2'd3; req_valid = 1'b1;
      check("not_ready_during_done", 32'(req_ready), 32'd0);
      @(negedge m2);
      check("ready_after_done", 32'(req_ready), 32'd1);
      check("idle_after_done", 32'(busy), 32'd0);
      @(negedge m2);
      req_valid = 1'b0;
      check("accept_one_after_done", 32'(busy), 32'd1);
      drain("drain_reset_op");

      // Reset mid write pulse of a CHIP_ERASE.
      push_ev(K_W, 27'hAAA, 8'hAA, 1'b0);
      issue(2'd2, 27'h0, 8'h00);
      n = 0;
      while (flash_we_n && n < 20) begin @(negedge m2); n++; end
      check("reached_we_pulse", 32'(flash_we_n), 32'd0);
      rst = 1'b1;
      @(negedge m2);
      check_reset_vals();
      rst = 1'b0;
      repeat (20) @(negedge m2);
      drain("drain_after_rst");

      check("strobe_invariants", 32'(viol), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
